// File: rtl/multicycle_control.sv
// Multicycle control sequencer for a small RISC-V datapath: owns the state register and IR,
// decodes ALU/immediate controls, handles the memory ready handshake and counts retired instructions.
module multicycle_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   output logic [3:0]  estado,
   output logic        alusrc,
   output logic [3:0]  alucontrol,
   output logic [11:0] immediate,
   output logic        branch,
   output logic        memread,
   output logic        memwrite,
   output logic        regwrite,
   output logic        memtoreg,
   output logic        pcwrite,
   output logic        pcwrite_cond,
   output logic        halted,
   output logic [31:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'b0000,
      S_DECODE    = 4'b0001,
      S_EXEC_R    = 4'b0010,
      S_MEM_READ  = 4'b0011,
      S_MEM_WRITE = 4'b0100,
      S_EXEC_MEM  = 4'b0101,
      S_EXEC_BEQ  = 4'b0110,
      S_WB_R      = 4'b0111,
      S_WB_LW     = 4'b1000,
      S_BR_DONE   = 4'b1001,
      S_HALT      = 4'b1111
   } state_t;

   state_t      r_state;
   logic [31:0] r_ir;
   logic [31:0] r_count;

   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic        w_is_r;
   logic        w_is_lw;
   logic        w_is_sw;
   logic        w_is_beq;
   logic        w_r_ok;
   logic [3:0]  w_r_alu;
   logic        w_active;
   logic        w_unused_ir;

   assign w_opcode    = r_ir[6:0];
   assign w_f3        = r_ir[14:12];
   assign w_f7        = r_ir[31:25];
   assign w_is_r      = (w_opcode == 7'b0110011);
   assign w_is_lw     = (w_opcode == 7'b0000011);
   assign w_is_sw     = (w_opcode == 7'b0100011);
   assign w_is_beq    = (w_opcode == 7'b1100011) && (w_f3 == 3'b000);
   assign w_active    = (r_state != S_FETCH) && (r_state != S_HALT);
   assign w_unused_ir = ^r_ir[19:15];

   // Supported R-type funct7/funct3 combinations and their ALU codes
   always_comb begin
      w_r_ok  = 1'b1;
      w_r_alu = 4'b0000;
      case ({w_f7, w_f3})
         10'b0000000_000: w_r_alu = 4'b0010;
         10'b0100000_000: w_r_alu = 4'b0110;
         10'b0000000_100: w_r_alu = 4'b0011;
         10'b0100000_101: w_r_alu = 4'b0101;
         default: begin
            w_r_ok  = 1'b0;
            w_r_alu = 4'b0000;
         end
      endcase
   end

   // Sequencer: state, instruction register and retired-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_ir    <= 32'h0000_0000;
         r_count <= 32'h0000_0000;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (mem_ready) begin
                  r_ir    <= instr;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (w_is_r && w_r_ok)        r_state <= S_EXEC_R;
               else if (w_is_lw || w_is_sw) r_state <= S_EXEC_MEM;
               else if (w_is_beq)           r_state <= S_EXEC_BEQ;
               else                         r_state <= S_HALT;
            end
            S_EXEC_R:   r_state <= S_WB_R;
            S_EXEC_MEM: r_state <= w_is_lw ? S_MEM_READ : S_MEM_WRITE;
            S_EXEC_BEQ: r_state <= S_BR_DONE;
            S_MEM_READ: begin
               if (mem_ready) r_state <= S_WB_LW;
            end
            S_MEM_WRITE: begin
               if (mem_ready) begin
                  r_state <= S_FETCH;
                  r_count <= r_count + 32'd1;
               end
            end
            S_WB_R, S_WB_LW, S_BR_DONE: begin
               r_state <= S_FETCH;
               r_count <= r_count + 32'd1;
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_HALT;
         endcase
      end
   end

   // ALU operand/operation and immediate decode, live from DECODE to the end of the instruction
   always_comb begin
      alusrc     = 1'b0;
      alucontrol = 4'b0000;
      immediate  = 12'h000;
      if (w_active) begin
         if (w_is_r && w_r_ok) begin
            alucontrol = w_r_alu;
         end else if (w_is_lw) begin
            alusrc     = 1'b1;
            alucontrol = 4'b0010;
            immediate  = r_ir[31:20];
         end else if (w_is_sw) begin
            alusrc     = 1'b1;
            alucontrol = 4'b0010;
            immediate  = {r_ir[31:25], r_ir[11:7]};
         end else if (w_is_beq) begin
            alusrc     = 1'b1;
            alucontrol = 4'b0110;
            immediate  = {r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8]};
         end else begin
            alusrc     = 1'b0;
            alucontrol = 4'b0000;
            immediate  = 12'h000;
         end
      end else begin
         alusrc     = 1'b0;
         alucontrol = 4'b0000;
         immediate  = 12'h000;
      end
   end

   assign estado       = r_state;
   assign instr_count  = r_count;
   assign memread      = (r_state == S_FETCH) || (r_state == S_MEM_READ);
   assign memwrite     = (r_state == S_MEM_WRITE);
   assign regwrite     = (r_state == S_WB_R) || (r_state == S_WB_LW);
   assign memtoreg     = (r_state == S_WB_LW);
   assign branch       = (r_state == S_EXEC_BEQ) || (r_state == S_BR_DONE);
   assign pcwrite_cond = (r_state == S_BR_DONE);
   assign halted       = (r_state == S_HALT);
   // The PC bump is held off while reset is low even if memory already signals ready
   assign pcwrite      = (r_state == S_FETCH) && mem_ready && rst_n;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven check of the multicycle sequencer plus hand-written lw wait, async reset and halt sequences.
module tb_multicycle_control;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        mem_ready;
   logic [3:0]  estado;
   logic        alusrc;
   logic [3:0]  alucontrol;
   logic [11:0] immediate;
   logic        branch;
   logic        memread;
   logic        memwrite;
   logic        regwrite;
   logic        memtoreg;
   logic        pcwrite;
   logic        pcwrite_cond;
   logic        halted;
   logic [31:0] instr_count;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [31:0] I_ADD = 32'h003100B3;
   localparam logic [31:0] I_SUB = 32'h403100B3;
   localparam logic [31:0] I_XOR = 32'h003140B3;
   localparam logic [31:0] I_SRA = 32'h403150B3;
   localparam logic [31:0] I_LW  = 32'h0080A283;
   localparam logic [31:0] I_SW  = 32'h0050A623;
   localparam logic [31:0] I_BEQ = 32'h00208863;
   localparam logic [31:0] I_ILL = 32'hFFFFFFFF;
   localparam logic [31:0] I_MUL = 32'h023100B3;
   localparam logic [31:0] I_BNE = 32'h00209863;

   // strobe order: branch, memread, memwrite, regwrite, memtoreg, pcwrite, pcwrite_cond, halted
   localparam logic [7:0] SB_NONE = 8'b00000000;
   localparam logic [7:0] SB_F    = 8'b01000000;
   localparam logic [7:0] SB_FPC  = 8'b01000100;
   localparam logic [7:0] SB_WBR  = 8'b00010000;
   localparam logic [7:0] SB_WBL  = 8'b00011000;
   localparam logic [7:0] SB_MW   = 8'b00100000;
   localparam logic [7:0] SB_BR   = 8'b10000000;
   localparam logic [7:0] SB_BRD  = 8'b10000010;
   localparam logic [7:0] SB_HALT = 8'b00000001;

   typedef struct {
      logic        rst;
      logic [31:0] ins;
      logic        rdy;
      logic [3:0]  st;
      logic        asrc;
      logic [3:0]  aluc;
      logic [11:0] imm;
      logic [7:0]  stb;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
      .estado(estado), .alusrc(alusrc), .alucontrol(alucontrol), .immediate(immediate),
      .branch(branch), .memread(memread), .memwrite(memwrite), .regwrite(regwrite),
      .memtoreg(memtoreg), .pcwrite(pcwrite), .pcwrite_cond(pcwrite_cond),
      .halted(halted), .instr_count(instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic addv(input logic rst, input logic [31:0] ins, input logic rdy, input logic [3:0] st,
                       input logic asrc, input logic [3:0] aluc, input logic [11:0] imm,
                       input logic [7:0] stb, input logic [31:0] cnt);
      vec_t v;
      v.rst = rst; v.ins = ins; v.rdy = rdy; v.st = st; v.asrc = asrc;
      v.aluc = aluc; v.imm = imm; v.stb = stb; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, check outputs at the falling edge, then step past the rising edge
   task automatic cyc(input string nm, input logic rst, input logic [31:0] ins, input logic rdy,
                      input logic [3:0] st, input logic asrc, input logic [3:0] aluc,
                      input logic [11:0] imm, input logic [7:0] stb, input logic [31:0] cnt);
      logic [28:0] act;
      logic [28:0] exp;
      rst_n     = rst;
      instr     = ins;
      mem_ready = rdy;
      @(negedge clk);
      act = {estado, alusrc, alucontrol, immediate, branch, memread, memwrite,
             regwrite, memtoreg, pcwrite, pcwrite_cond, halted};
      exp = {st, asrc, aluc, imm, stb};
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s ctl: got st=%h asrc=%b alu=%h imm=%h stb=%b, want st=%h asrc=%b alu=%h imm=%h stb=%b",
                  nm, act[28:25], act[24], act[23:20], act[19:8], act[7:0],
                  exp[28:25], exp[24], exp[23:20], exp[19:8], exp[7:0]);
      end
      n_chk++;
      if (instr_count !== cnt) begin
         n_fail++;
         $display("FAIL %s instr_count: got %0d want %0d", nm, instr_count, cnt);
      end
      @(posedge clk);
      #1;
   endtask

   logic [31:0] rops [3];
   logic [3:0]  ralu [3];

   initial begin
      rst_n     = 1'b0;
      instr     = 32'h0000_0000;
      mem_ready = 1'b0;

      // add, sw, beq, then a fetch wait, add again
      addv(1'b0, I_ADD, 1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_F,    32'd0);
      addv(1'b1, I_ADD, 1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_FPC,  32'd0);
      addv(1'b1, I_ADD, 1'b1, 4'h1, 1'b0, 4'h2, 12'h000, SB_NONE, 32'd0);
      addv(1'b1, I_ADD, 1'b1, 4'h2, 1'b0, 4'h2, 12'h000, SB_NONE, 32'd0);
      addv(1'b1, I_ADD, 1'b1, 4'h7, 1'b0, 4'h2, 12'h000, SB_WBR,  32'd0);
      addv(1'b1, I_SW,  1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_FPC,  32'd1);
      addv(1'b1, I_SW,  1'b1, 4'h1, 1'b1, 4'h2, 12'h00C, SB_NONE, 32'd1);
      addv(1'b1, I_SW,  1'b1, 4'h5, 1'b1, 4'h2, 12'h00C, SB_NONE, 32'd1);
      addv(1'b1, I_SW,  1'b1, 4'h4, 1'b1, 4'h2, 12'h00C, SB_MW,   32'd1);
      addv(1'b1, I_BEQ, 1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_FPC,  32'd2);
      addv(1'b1, I_BEQ, 1'b1, 4'h1, 1'b1, 4'h6, 12'h008, SB_NONE, 32'd2);
      addv(1'b1, I_BEQ, 1'b1, 4'h6, 1'b1, 4'h6, 12'h008, SB_BR,   32'd2);
      addv(1'b1, I_BEQ, 1'b1, 4'h9, 1'b1, 4'h6, 12'h008, SB_BRD,  32'd2);
      addv(1'b1, I_ADD, 1'b0, 4'h0, 1'b0, 4'h0, 12'h000, SB_F,    32'd3);
      addv(1'b1, I_ADD, 1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_FPC,  32'd3);
      addv(1'b1, I_ADD, 1'b1, 4'h1, 1'b0, 4'h2, 12'h000, SB_NONE, 32'd3);
      addv(1'b1, I_ADD, 1'b1, 4'h2, 1'b0, 4'h2, 12'h000, SB_NONE, 32'd3);
      addv(1'b1, I_ADD, 1'b1, 4'h7, 1'b0, 4'h2, 12'h000, SB_WBR,  32'd3);
      // sub, xor, sra with mem_ready low outside FETCH (must be ignored)
      rops[0] = I_SUB; ralu[0] = 4'h6;
      rops[1] = I_XOR; ralu[1] = 4'h3;
      rops[2] = I_SRA; ralu[2] = 4'h5;
      for (int k = 0; k < 3; k++) begin
         addv(1'b1, rops[k], 1'b1, 4'h0, 1'b0, 4'h0,    12'h000, SB_FPC,  32'd4 + 32'(k));
         addv(1'b1, rops[k], 1'b0, 4'h1, 1'b0, ralu[k], 12'h000, SB_NONE, 32'd4 + 32'(k));
         addv(1'b1, rops[k], 1'b0, 4'h2, 1'b0, ralu[k], 12'h000, SB_NONE, 32'd4 + 32'(k));
         addv(1'b1, rops[k], 1'b0, 4'h7, 1'b0, ralu[k], 12'h000, SB_WBR,  32'd4 + 32'(k));
      end
      addv(1'b1, I_LW, 1'b0, 4'h0, 1'b0, 4'h0, 12'h000, SB_F, 32'd7);

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ins, vecs[i].rdy, vecs[i].st,
             vecs[i].asrc, vecs[i].aluc, vecs[i].imm, vecs[i].stb, vecs[i].cnt);
      end

      // lw with three wait cycles in MEM_READ: 8 cycles total
      cyc("lw_fetch", 1'b1, I_LW, 1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_FPC,  32'd7);
      cyc("lw_dec",   1'b1, I_LW, 1'b1, 4'h1, 1'b1, 4'h2, 12'h008, SB_NONE, 32'd7);
      cyc("lw_exec",  1'b1, I_LW, 1'b1, 4'h5, 1'b1, 4'h2, 12'h008, SB_NONE, 32'd7);
      for (int w = 0; w < 3; w++)
         cyc("lw_wait", 1'b1, I_LW, 1'b0, 4'h3, 1'b1, 4'h2, 12'h008, SB_F, 32'd7);
      cyc("lw_mr",    1'b1, I_LW, 1'b1, 4'h3, 1'b1, 4'h2, 12'h008, SB_F,    32'd7);
      cyc("lw_wb",    1'b1, I_LW, 1'b1, 4'h8, 1'b1, 4'h2, 12'h008, SB_WBL,  32'd7);
      cyc("lw_done",  1'b1, I_LW, 1'b0, 4'h0, 1'b0, 4'h0, 12'h000, SB_F,    32'd8);

      // asynchronous reset while waiting in MEM_READ
      cyc("rst_fetch", 1'b1, I_LW, 1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_FPC,  32'd8);
      cyc("rst_dec",   1'b1, I_LW, 1'b1, 4'h1, 1'b1, 4'h2, 12'h008, SB_NONE, 32'd8);
      cyc("rst_exec",  1'b1, I_LW, 1'b1, 4'h5, 1'b1, 4'h2, 12'h008, SB_NONE, 32'd8);
      cyc("rst_mr",    1'b1, I_LW, 1'b0, 4'h3, 1'b1, 4'h2, 12'h008, SB_F,    32'd8);
      cyc("rst_async", 1'b0, I_LW, 1'b0, 4'h0, 1'b0, 4'h0, 12'h000, SB_F,    32'd0);

      // illegal opcode: halt, frozen counter, reset recovery
      cyc("h_add_f",  1'b1, I_ADD, 1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_FPC,  32'd0);
      cyc("h_add_d",  1'b1, I_ADD, 1'b1, 4'h1, 1'b0, 4'h2, 12'h000, SB_NONE, 32'd0);
      cyc("h_add_e",  1'b1, I_ADD, 1'b1, 4'h2, 1'b0, 4'h2, 12'h000, SB_NONE, 32'd0);
      cyc("h_add_wb", 1'b1, I_ADD, 1'b1, 4'h7, 1'b0, 4'h2, 12'h000, SB_WBR,  32'd0);
      cyc("h_ill_f",  1'b1, I_ILL, 1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_FPC,  32'd1);
      cyc("h_ill_d",  1'b1, I_ILL, 1'b1, 4'h1, 1'b0, 4'h0, 12'h000, SB_NONE, 32'd1);
      for (int i = 0; i < 10; i++)
         cyc("h_halt", 1'b1, I_ILL, i[0], 4'hF, 1'b0, 4'h0, 12'h000, SB_HALT, 32'd1);
      cyc("h_rst",    1'b0, I_ILL, 1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_F,    32'd0);

      // unsupported R-type funct7 and non-beq branch also halt
      cyc("mul_f",    1'b1, I_MUL, 1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_FPC,  32'd0);
      cyc("mul_d",    1'b1, I_MUL, 1'b1, 4'h1, 1'b0, 4'h0, 12'h000, SB_NONE, 32'd0);
      cyc("mul_halt", 1'b1, I_MUL, 1'b1, 4'hF, 1'b0, 4'h0, 12'h000, SB_HALT, 32'd0);
      cyc("bne_rst",  1'b0, I_BNE, 1'b0, 4'h0, 1'b0, 4'h0, 12'h000, SB_F,    32'd0);
      cyc("bne_f",    1'b1, I_BNE, 1'b1, 4'h0, 1'b0, 4'h0, 12'h000, SB_FPC,  32'd0);
      cyc("bne_d",    1'b1, I_BNE, 1'b1, 4'h1, 1'b0, 4'h0, 12'h000, SB_NONE, 32'd0);
      cyc("bne_halt", 1'b1, I_BNE, 1'b1, 4'hF, 1'b0, 4'h0, 12'h000, SB_HALT, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
